// File: rtl/main_memory.sv
// Two-client line store with a fixed access latency. Clients are the instruction cache (0) and the data cache (1).
// Define MAIN_MEMORY_TRACE_EN to print one simulation line per completed transaction.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module main_memory #(
  parameter int WIDTH   = `MEMORY_WIDTH,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             p0_write_req,
  input  logic [31:0]      p0_write_addr,
  input  logic [WIDTH-1:0] p0_write_data,
  output logic             p0_write_ack,
  input  logic             p0_read_req,
  input  logic [31:0]      p0_read_addr,
  output logic [WIDTH-1:0] p0_read_data,
  output logic             p0_read_ack,

  input  logic             p1_write_req,
  input  logic [31:0]      p1_write_addr,
  input  logic [WIDTH-1:0] p1_write_data,
  output logic             p1_write_ack,
  input  logic             p1_read_req,
  input  logic [31:0]      p1_read_addr,
  output logic [WIDTH-1:0] p1_read_data,
  output logic             p1_read_ack
);

  localparam int WB = $clog2(WIDTH / 8);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             cur_client;
  logic             cur_write;
  logic [IW-1:0]    cur_line;
  logic [WIDTH-1:0] cur_data;
  logic             prio;

  logic [WIDTH-1:0] store [DEPTH];

  logic             p0_any;
  logic             p1_any;
  logic             grant;
  logic             grant_write;
  logic [31:0]      grant_addr;
  logic [WIDTH-1:0] grant_data;
  logic [IW-1:0]    grant_line;
  logic             access_now;

  // Offset bits and bits above the index only alias lines, so most address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^grant_addr;

  always_comb begin
    p0_any      = p0_write_req | p0_read_req;
    p1_any      = p1_write_req | p1_read_req;
    grant       = 1'b0;
    if (p0_any && p1_any)
      grant = prio;
    else if (p1_any)
      grant = 1'b1;
    // A client's write-back goes before its own fill so the victim reaches memory first.
    grant_write = grant ? p1_write_req : p0_write_req;
    grant_data  = grant ? p1_write_data : p0_write_data;
    if (grant)
      grant_addr = p1_write_req ? p1_write_addr : p1_read_addr;
    else
      grant_addr = p0_write_req ? p0_write_addr : p0_read_addr;
    grant_line  = grant_addr[WB+IW-1:WB];
  end

  assign access_now = (state == BUSY) && (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      prio         <= 1'b0;
      cur_client   <= 1'b0;
      cur_write    <= 1'b0;
      cur_line     <= '0;
      cur_data     <= '0;
      p0_write_ack <= 1'b0;
      p0_read_ack  <= 1'b0;
      p1_write_ack <= 1'b0;
      p1_read_ack  <= 1'b0;
      p0_read_data <= '0;
      p1_read_data <= '0;
    end else begin
      p0_write_ack <= 1'b0;
      p0_read_ack  <= 1'b0;
      p1_write_ack <= 1'b0;
      p1_read_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_any || p1_any) begin
            cur_client <= grant;
            cur_write  <= grant_write;
            cur_line   <= grant_line;
            cur_data   <= grant_data;
            count      <= CW'(LATENCY - 1);
            prio       <= ~grant;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (count == '0) begin
            if (!cur_write) begin
              if (cur_client)
                p1_read_data <= store[cur_line];
              else
                p0_read_data <= store[cur_line];
            end
            p0_write_ack <= !cur_client &&  cur_write;
            p0_read_ack  <= !cur_client && !cur_write;
            p1_write_ack <=  cur_client &&  cur_write;
            p1_read_ack  <=  cur_client && !cur_write;
            state        <= ACK;
          end else begin
            count <= count - 1'b1;
          end
        end
        // Requests are ignored here so a client dropping req on its ack is not served twice.
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && access_now && cur_write)
      store[cur_line] <= cur_data;
  end

`ifdef MAIN_MEMORY_TRACE_EN
  logic [15:0] trace_addr;

  always_ff @(posedge clk) begin
    if (state == IDLE)
      trace_addr <= grant_addr[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset && access_now)
      $display("main_memory: client %0d %s addr %h data %h", cur_client,
               cur_write ? "W" : "R", trace_addr,
               cur_write ? cur_data : store[cur_line]);
  end
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: a vector table of single transactions plus
// hand-written sequences for arbitration, write-before-read, reset abort and aliasing.
module tb_main_memory;

  localparam int W = 128;

  logic         clk;
  logic         reset;
  logic         p0_write_req, p0_read_req, p1_write_req, p1_read_req;
  logic [31:0]  p0_write_addr, p0_read_addr, p1_write_addr, p1_read_addr;
  logic [W-1:0] p0_write_data, p1_write_data;
  logic [W-1:0] p0_read_data, p1_read_data;
  logic         p0_write_ack, p0_read_ack, p1_write_ack, p1_read_ack;

  int n_checks;
  int n_errors;

  main_memory #(.WIDTH(W), .DEPTH(1024), .LATENCY(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .p0_write_req (p0_write_req),
    .p0_write_addr(p0_write_addr),
    .p0_write_data(p0_write_data),
    .p0_write_ack (p0_write_ack),
    .p0_read_req  (p0_read_req),
    .p0_read_addr (p0_read_addr),
    .p0_read_data (p0_read_data),
    .p0_read_ack  (p0_read_ack),
    .p1_write_req (p1_write_req),
    .p1_write_addr(p1_write_addr),
    .p1_write_data(p1_write_data),
    .p1_write_ack (p1_write_ack),
    .p1_read_req  (p1_read_req),
    .p1_read_addr (p1_read_addr),
    .p1_read_data (p1_read_data),
    .p1_read_ack  (p1_read_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         client;
    logic         is_write;
    logic [31:0]  addr;
    logic [W-1:0] data;
    logic [W-1:0] exp_data;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  localparam logic [W-1:0] DA = {16{8'hA5}};
  localparam logic [W-1:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [W-1:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [W-1:0] D2 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
  localparam logic [W-1:0] D3 = 128'h0F0F_0F0F_F0F0_F0F0_1357_9BDF_2468_ACE0;
  localparam logic [W-1:0] D5 = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  task automatic check_output(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic clear_reqs();
    p0_write_req = 1'b0;
    p0_read_req  = 1'b0;
    p1_write_req = 1'b0;
    p1_read_req  = 1'b0;
  endtask

  function automatic logic [3:0] ack_vec();
    return {p1_read_ack, p1_write_ack, p0_read_ack, p0_write_ack};
  endfunction

  // One transaction from one client; req drops right after it has been sampled.
  task automatic apply_stimulus(input logic client, input logic is_write, input logic [31:0] addr,
                                input logic [W-1:0] data, output int lat, output logic other,
                                output logic [W-1:0] rdata);
    logic [3:0] mine;
    logic       seen;
    mine  = 4'b0001 << {client, ~is_write};
    seen  = 1'b0;
    other = 1'b0;
    lat   = -1;
    @(negedge clk);
    if (client) begin
      p1_write_req = is_write;  p1_write_addr = addr;  p1_write_data = data;
      p1_read_req  = !is_write; p1_read_addr  = addr;
    end else begin
      p0_write_req = is_write;  p0_write_addr = addr;  p0_write_data = data;
      p0_read_req  = !is_write; p0_read_addr  = addr;
    end
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) clear_reqs();
      if (ack_vec() != 4'b0000 && ack_vec() != mine) other = 1'b1;
      if (ack_vec() == mine) begin
        seen = 1'b1;
        lat  = k - 1;
      end
    end
    clear_reqs();
    rdata = client ? p1_read_data : p0_read_data;
  endtask

  task automatic both_read(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input int exp_k0, input int exp_k1);
    int   k0, k1;
    logic both_seen;
    k0 = -1; k1 = -1; both_seen = 1'b0;
    @(negedge clk);
    p0_read_req = 1'b1; p0_read_addr = a0;
    p1_read_req = 1'b1; p1_read_addr = a1;
    for (int k = 1; k <= 30 && (k0 < 0 || k1 < 0); k++) begin
      @(negedge clk);
      if (p0_read_ack && p1_read_ack) both_seen = 1'b1;
      if (p0_read_ack && k0 < 0) begin k0 = k; p0_read_req = 1'b0; end
      if (p1_read_ack && k1 < 0) begin k1 = k; p1_read_req = 1'b0; end
    end
    clear_reqs();
    check_output({tag, "_ack_cycle_p0"}, W'(k0), W'(exp_k0));
    check_output({tag, "_ack_cycle_p1"}, W'(k1), W'(exp_k1));
    check_output({tag, "_double_ack"}, W'(both_seen), '0);
    check_output({tag, "_data_p0"}, p0_read_data, e0);
    check_output({tag, "_data_p1"}, p1_read_data, e1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_acks"}, W'(ack_vec()), '0);
    check_output({tag, "_p0_read_data"}, p0_read_data, '0);
    check_output({tag, "_p1_read_data"}, p1_read_data, '0);
  endtask

  initial begin
    int         lat;
    logic       other;
    logic [W-1:0] rdata;
    int         kw, kr;
    logic       any_ack;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    clear_reqs();
    p0_write_addr = '0; p0_read_addr = '0; p0_write_data = '0;
    p1_write_addr = '0; p1_read_addr = '0; p1_write_data = '0;

    vecs[0] = '{client: 1'b1, is_write: 1'b1, addr: 32'h0000_0040, data: DA, exp_data: '0};
    vecs[1] = '{client: 1'b1, is_write: 1'b0, addr: 32'h0000_0040, data: '0, exp_data: DA};
    vecs[2] = '{client: 1'b0, is_write: 1'b1, addr: 32'h0000_4010, data: D0, exp_data: '0};
    vecs[3] = '{client: 1'b0, is_write: 1'b0, addr: 32'h0000_0010, data: '0, exp_data: D0};
    vecs[4] = '{client: 1'b1, is_write: 1'b0, addr: 32'h0000_0014, data: '0, exp_data: D0};
    vecs[5] = '{client: 1'b0, is_write: 1'b1, addr: 32'h0000_0080, data: D1, exp_data: '0};
    vecs[6] = '{client: 1'b1, is_write: 1'b1, addr: 32'h0000_0200, data: D2, exp_data: '0};
    vecs[7] = '{client: 1'b0, is_write: 1'b0, addr: 32'h0000_0080, data: '0, exp_data: D1};
    vecs[8] = '{client: 1'b1, is_write: 1'b0, addr: 32'h0000_0040, data: '0, exp_data: DA};
    vecs[9] = '{client: 1'b0, is_write: 1'b0, addr: 32'h0000_0200, data: '0, exp_data: D2};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i].client, vecs[i].is_write, vecs[i].addr, vecs[i].data, lat, other, rdata);
      check_output($sformatf("vec%0d_latency", i), W'(lat), W'(4));
      check_output($sformatf("vec%0d_stray_ack", i), W'(other), '0);
      if (!vecs[i].is_write)
        check_output($sformatf("vec%0d_read_data", i), rdata, vecs[i].exp_data);
    end
    check_output("hold_p0_read_data", p0_read_data, D2);
    check_output("hold_p1_read_data", p1_read_data, DA);

    $display("[TB] reset clears read data, then both clients read together");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check_reset_outputs("reset_pulse");
    both_read("arb_after_reset", 32'h40, 32'h80, DA, D1, 5, 11);

    apply_stimulus(1'b0, 1'b0, 32'h0000_0040, '0, lat, other, rdata);
    check_output("rr_setup_data", rdata, DA);
    both_read("arb_round_robin", 32'h200, 32'h10, D2, D0, 11, 5);

    $display("[TB] client 1 write-back and fill together");
    kw = -1; kr = -1;
    @(negedge clk);
    p1_write_req = 1'b1; p1_write_addr = 32'h100; p1_write_data = D3;
    p1_read_req  = 1'b1; p1_read_addr  = 32'h200;
    for (int k = 1; k <= 30 && (kw < 0 || kr < 0); k++) begin
      @(negedge clk);
      if (p1_write_ack && kw < 0) begin kw = k; p1_write_req = 1'b0; end
      if (p1_read_ack && kr < 0) begin kr = k; p1_read_req = 1'b0; end
    end
    clear_reqs();
    check_output("wb_first_write_ack", W'(kw), W'(5));
    check_output("wb_first_read_ack", W'(kr), W'(11));
    check_output("wb_first_read_data", p1_read_data, D2);
    apply_stimulus(1'b0, 1'b0, 32'h0000_0100, '0, lat, other, rdata);
    check_output("wb_first_store_updated", rdata, D3);

    $display("[TB] reset two cycles into a write");
    any_ack = 1'b0;
    @(negedge clk);
    p0_write_req = 1'b1; p0_write_addr = 32'h80; p0_write_data = D5;
    @(negedge clk); clear_reqs(); any_ack |= |ack_vec();
    @(negedge clk); reset = 1'b1; any_ack |= |ack_vec();
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      any_ack |= |ack_vec();
    end
    check_output("abort_no_ack", W'(any_ack), '0);
    apply_stimulus(1'b0, 1'b0, 32'h0000_0080, '0, lat, other, rdata);
    check_output("abort_store_unchanged", rdata, D1);
    check_output("abort_read_latency", W'(lat), W'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
